comparator_serial: RTL and testbench



---
 rtl/comparator_serial_if.sv | 34 +++
 rtl/comparator_serial.sv | 85 ++++++++
 tb/tb_comparator_serial.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/comparator_serial_if.sv
// Handshake and bit-pair bus between the serial operand shifters and the
// bit-serial magnitude comparator.
interface comparator_serial_if;
    logic i_start;
    logic i_bit_valid;
    logic i_a_bit;
    logic i_b_bit;
    logic o_gt;
    logic o_eq;
    logic o_busy;
    logic o_done;

    modport master (
        output i_start,
        output i_bit_valid,
        output i_a_bit,
        output i_b_bit,
        input  o_gt,
        input  o_eq,
        input  o_busy,
        input  o_done
    );

    modport slave (
        input  i_start,
        input  i_bit_valid,
        input  i_a_bit,
        input  i_b_bit,
        output o_gt,
        output o_eq,
        output o_busy,
        output o_done
    );
endinterface

// File: rtl/comparator_serial.sv
// Bit-serial unsigned magnitude comparator. Operands arrive MSB-first, one bit
// pair per accepted cycle; the GT/EQ cascade is held in registers between bits.
module comparator_serial #(
    parameter int N = 3
) (
    input  logic                clk,
    input  logic                rst,
    comparator_serial_if.slave  bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_gt;
    logic          r_eq;
    logic          r_busy;
    logic          r_done;

    // Control FSM and cascade registers; busy/done are decoded a cycle early so
    // every output leaves a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_gt    <= 1'b0;
            r_eq    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.i_start) begin
                        r_gt    <= 1'b0;
                        r_eq    <= 1'b1;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (bus.i_bit_valid) begin
                        // Once EQ drops, both terms freeze: the first differing bit decides.
                        r_gt <= r_gt | (r_eq & bus.i_a_bit & ~bus.i_b_bit);
                        r_eq <= r_eq & ~(bus.i_a_bit ^ bus.i_b_bit);
                        if (r_cnt == LAST_CNT) begin
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_gt   = r_gt;
    assign bus.o_eq   = r_eq;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial: directed scenarios plus randomized
// operands, stalls and stray starts, checked against plain integer comparison.
module tb_comparator_serial;

    localparam int N = 3;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   done_cnt;

    comparator_serial_if u_if ();

    comparator_serial #(.N(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts done pulses seen on rising edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt <= done_cnt;
        end else if (u_if.o_done) begin
            done_cnt <= done_cnt + 1;
        end else begin
            done_cnt <= done_cnt;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full comparison; stall_len idle cycles inserted before bit index
    // stall_pos, and stray starts during SHIFT/DONE when noise is set.
    task automatic run_cmp(input int a, input int b, input int stall_pos,
                           input int stall_len, input bit noise);
        int  done_before;
        int  cycles;
        bit  exp_gt;
        bit  exp_eq;
        logic hold_gt;
        logic hold_eq;
        exp_gt      = (a > b);
        exp_eq      = (a == b);
        done_before = done_cnt;
        u_if.i_start = 1'b1;
        step();
        cycles = 1;
        u_if.i_start = noise;
        check_value("busy_shift", u_if.o_busy, 1'b1);
        for (int i = N - 1; i >= 0; i--) begin
            if (i == stall_pos) begin
                hold_gt = u_if.o_gt;
                hold_eq = u_if.o_eq;
                for (int s = 0; s < stall_len; s++) begin
                    u_if.i_bit_valid = 1'b0;
                    u_if.i_a_bit     = 1'($urandom);
                    u_if.i_b_bit     = 1'($urandom);
                    step();
                    cycles++;
                end
                check_value("stall_gt", u_if.o_gt, hold_gt);
                check_value("stall_eq", u_if.o_eq, hold_eq);
            end
            u_if.i_bit_valid = 1'b1;
            u_if.i_a_bit     = 1'((a >> i) & 1);
            u_if.i_b_bit     = 1'((b >> i) & 1);
            step();
            cycles++;
        end
        u_if.i_bit_valid = 1'b0;
        u_if.i_a_bit     = 1'($urandom);
        check_value("latency", cycles, N + 1 + ((stall_pos >= 0) ? stall_len : 0));
        check_value("done", u_if.o_done, 1'b1);
        check_value("busy_done", u_if.o_busy, 1'b1);
        check_value("gt", u_if.o_gt, exp_gt);
        check_value("eq", u_if.o_eq, exp_eq);
        check_value("not_both", u_if.o_gt & u_if.o_eq, 1'b0);
        step();
        u_if.i_start = 1'b0;
        check_value("done_drop", u_if.o_done, 1'b0);
        check_value("busy_idle", u_if.o_busy, 1'b0);
        check_value("gt_hold", u_if.o_gt, exp_gt);
        check_value("eq_hold", u_if.o_eq, exp_eq);
        step();
        check_value("still_idle", u_if.o_busy, 1'b0);
        check_value("done_pulses", done_cnt - done_before, 1);
    endtask

    initial begin
        int done_before;
        n_tests          = 0;
        n_fail           = 0;
        done_cnt         = 0;
        rst              = 1'b0;
        u_if.i_start     = 1'b0;
        u_if.i_bit_valid = 1'b0;
        u_if.i_a_bit     = 1'b0;
        u_if.i_b_bit     = 1'b0;

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_value("rst_gt", u_if.o_gt, 1'b0);
        check_value("rst_eq", u_if.o_eq, 1'b1);
        check_value("rst_busy", u_if.o_busy, 1'b0);
        check_value("rst_done", u_if.o_done, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();

        run_cmp(5, 3, -1, 0, 1'b0);
        run_cmp(6, 6, -1, 0, 1'b0);
        run_cmp(2, 4, -1, 0, 1'b0);
        run_cmp(4, 5, 1, 2, 1'b0);
        run_cmp(4, 5, -1, 0, 1'b0);
        run_cmp(3, 1, -1, 0, 1'b1);
        run_cmp(7, 0, -1, 0, 1'b0);
        run_cmp(0, 7, 0, 3, 1'b1);

        // Abort A=7, B=0 after two accepted bits
        done_before = done_cnt;
        u_if.i_start = 1'b1;
        step();
        u_if.i_start = 1'b0;
        for (int i = N - 1; i >= N - 2; i--) begin
            u_if.i_bit_valid = 1'b1;
            u_if.i_a_bit     = 1'b1;
            u_if.i_b_bit     = 1'b0;
            step();
        end
        u_if.i_bit_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_value("abort_gt", u_if.o_gt, 1'b0);
        check_value("abort_eq", u_if.o_eq, 1'b1);
        check_value("abort_busy", u_if.o_busy, 1'b0);
        check_value("abort_done", u_if.o_done, 1'b0);
        step();
        rst = 1'b0;
        step();
        step();
        check_value("abort_no_done", done_cnt - done_before, 0);
        check_value("abort_idle", u_if.o_busy, 1'b0);
        run_cmp(0, 0, -1, 0, 1'b0);

        for (int k = 0; k < 40; k++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, (1 << N) - 1));
            rb = (k % 4 == 0) ? ra : int'($urandom_range(0, (1 << N) - 1));
            run_cmp(ra, rb, int'($urandom_range(0, N)) - 1,
                    int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
